// File: rtl/cursor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cursor_pkg
// Brief    : Shared constants, types and the saturating step helper for the
//            measurement cursor unit.
// Revision : 1.0
// ============================================================================
package cursor_pkg;

    localparam int CURSOR_ID_W       = 3;
    localparam int DEF_COORD_W       = 11;
    localparam int DEF_STEP          = 16;
    localparam int DEF_POS_MIN       = 16;
    localparam int DEF_POS_MAX       = 1008;
    localparam int DEF_POS_DEFAULT   = 512;
    localparam int DEF_RESET_SPACING = 64;
    // Wide enough for any COORD_W up to 16 plus one carry bit
    localparam int CALC_W            = 17;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } step_dir_e;

    function automatic logic [CALC_W-1:0] clamp_step(
        input logic [CALC_W-1:0] pos,
        input step_dir_e         dir,
        input logic [CALC_W-1:0] step,
        input logic [CALC_W-1:0] pos_min,
        input logic [CALC_W-1:0] pos_max
    );
        logic [CALC_W-1:0] w_sum;
        w_sum = pos + step;
        if (dir == DIR_INC) begin
            return (w_sum > pos_max) ? pos_max : w_sum;
        end
        return (pos < pos_min + step) ? pos_min : pos - step;
    endfunction

endpackage : cursor_pkg
`default_nettype wire

// File: rtl/anti_rebote.sv
`default_nettype none
// ============================================================================
// Module   : anti_rebote
// Brief    : Debouncer; output follows input once it has been stable for
//            N_CYCLES consecutive clocks.
// Revision : 1.0
// ============================================================================
module anti_rebote #(
    parameter int   N_CYCLES = 1000000,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk_fpga,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int c_CNT_W = $clog2(N_CYCLES + 1);

    logic               r_out;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            r_out <= RST_VAL;
            r_cnt <= '0;
        end else if (din == r_out) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_W'(N_CYCLES - 1)) begin
            r_out <= din;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    assign dout = r_out;

endmodule : anti_rebote
`default_nettype wire

// File: rtl/btn_repeat.sv
`default_nettype none
// ============================================================================
// Module   : btn_repeat
// Brief    : Debounced level to one-cycle step pulses: press edge, then
//            auto-repeat after REPEAT_DELAY and every REPEAT_PERIOD while held.
// Revision : 1.0
// ============================================================================
module btn_repeat #(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic clk_fpga,
    input  logic rst,
    input  logic lvl,
    input  logic clr,
    output logic step
);

    localparam int c_CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic               r_prev;
    logic               r_rep;
    logic [c_CNT_W-1:0] r_cnt;
    logic               w_edge;
    logic               w_rep_hit;

    // r_prev resets high so a button still held through reset needs a re-press
    assign w_edge    = lvl & ~r_prev & ~clr;
    assign w_rep_hit = (r_cnt != '0) &&
                       (r_cnt == (r_rep ? c_CNT_W'(REPEAT_PERIOD) : c_CNT_W'(REPEAT_DELAY)));
    assign step      = w_edge | (lvl & ~clr & w_rep_hit);

    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            r_prev <= 1'b1;
            r_rep  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= lvl;
            if (!lvl || clr) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (w_edge) begin
                r_cnt <= c_CNT_W'(1);
                r_rep <= 1'b0;
            end else if (r_cnt != '0) begin
                if (w_rep_hit) begin
                    r_cnt <= c_CNT_W'(1);
                    r_rep <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end
        end
    end

endmodule : btn_repeat
`default_nettype wire

// File: rtl/sincronizador.sv
`default_nettype none
// ============================================================================
// Module   : sincronizador
// Brief    : Two-flop synchroniser for an asynchronous button input.
// Revision : 1.0
// ============================================================================
module sincronizador #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_fpga,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
        end
    end

    assign dout = r_sync;

endmodule : sincronizador
`default_nettype wire

// File: rtl/cursor_bar_multi.sv
`default_nettype none
// ============================================================================
// Module   : cursor_bar_multi
// Brief    : N movable measurement cursors for the scope VGA overlay, with
//            button control, pixel hit test and cursor 0/1 distance.
// Revision : 1.0
// ============================================================================
module cursor_bar_multi
    import cursor_pkg::*;
#(
    parameter int N_CURSORS       = 2,
    parameter int COORD_W         = DEF_COORD_W,
    parameter int STEP            = DEF_STEP,
    parameter int POS_MIN         = DEF_POS_MIN,
    parameter int POS_MAX         = DEF_POS_MAX,
    parameter int POS_DEFAULT     = DEF_POS_DEFAULT,
    parameter int RESET_SPACING   = DEF_RESET_SPACING,
    parameter int LINE_W          = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit DEBOUNCE_BYPASS = 1'b0,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                           clk_fpga,
    input  logic                           rst,
    input  logic                           btn_dec,
    input  logic                           btn_inc,
    input  logic                           btn_sel,
    input  logic [COORD_W-1:0]             pix_coord,
    output logic                           in_cursor_line,
    output logic [CURSOR_ID_W-1:0]         cursor_hit_id,
    output logic [CURSOR_ID_W-1:0]         active_id,
    output logic [N_CURSORS*COORD_W-1:0]   cursor_pos,
    output logic [COORD_W-1:0]             cursor_delta
);

    localparam int c_IDX_W     = (N_CURSORS > 1) ? $clog2(N_CURSORS) : 1;
    localparam int c_HIT_W     = COORD_W + 1;
    localparam int c_RST_DELTA = (N_CURSORS > 1) ?
                                 ((RESET_SPACING < 0) ? -RESET_SPACING : RESET_SPACING) : 0;

    if (N_CURSORS < 1 || N_CURSORS > 8) begin : g_err_n
        $error("cursor_bar_multi: N_CURSORS must be 1..8");
    end
    if (COORD_W > CALC_W - 1 || LINE_W < 1) begin : g_err_w
        $error("cursor_bar_multi: COORD_W too wide or LINE_W < 1");
    end
    if (POS_MAX + LINE_W - 1 >= (1 << COORD_W)) begin : g_err_ovf
        $error("cursor_bar_multi: POS_MAX+LINE_W-1 overflows COORD_W");
    end
    for (genvar gi = 0; gi < N_CURSORS; gi++) begin : g_chk
        if (POS_DEFAULT + gi*RESET_SPACING < POS_MIN ||
            POS_DEFAULT + gi*RESET_SPACING > POS_MAX) begin : g_err_rst
            $error("cursor_bar_multi: reset position outside [POS_MIN,POS_MAX]");
        end
    end

    // Button front end: index 0 = dec, 1 = inc, 2 = sel
    logic [2:0] w_raw;
    logic [2:0] w_sync;
    logic [2:0] w_lvl;

    assign w_raw = {btn_sel, btn_inc, btn_dec};

    for (genvar gb = 0; gb < 3; gb++) begin : g_btn
        sincronizador #(.RST_VAL(1'b1)) u_sync (
            .clk_fpga (clk_fpga),
            .rst      (rst),
            .din      (w_raw[gb]),
            .dout     (w_sync[gb])
        );
        if (DEBOUNCE_BYPASS) begin : g_bypass
            assign w_lvl[gb] = w_sync[gb];
        end else begin : g_deb
            anti_rebote #(.N_CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_deb (
                .clk_fpga (clk_fpga),
                .rst      (rst),
                .din      (w_sync[gb]),
                .dout     (w_lvl[gb])
            );
        end
    end

    logic w_both;
    logic w_dec_req;
    logic w_inc_req;
    logic r_sel_prev;
    logic w_sel_edge;

    assign w_both = w_lvl[0] & w_lvl[1];

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_dec (
        .clk_fpga (clk_fpga),
        .rst      (rst),
        .lvl      (w_lvl[0]),
        .clr      (w_both),
        .step     (w_dec_req)
    );

    btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_rep_inc (
        .clk_fpga (clk_fpga),
        .rst      (rst),
        .lvl      (w_lvl[1]),
        .clr      (w_both),
        .step     (w_inc_req)
    );

    assign w_sel_edge = w_lvl[2] & ~r_sel_prev;

    logic [COORD_W-1:0]     r_pos [N_CURSORS];
    logic [CURSOR_ID_W-1:0] r_active;
    logic [c_IDX_W-1:0]     w_idx;
    logic [N_CURSORS*COORD_W-1:0] r_cursor_pos;
    logic [COORD_W-1:0]     r_delta;
    logic [COORD_W-1:0]     w_delta;

    assign w_idx = r_active[c_IDX_W-1:0];

    // Moves use the pre-select active id; a simultaneous select lands next cycle
    always_ff @(posedge clk_fpga or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CURSORS; i++) begin
                r_pos[i]                          <= COORD_W'(POS_DEFAULT + i*RESET_SPACING);
                r_cursor_pos[i*COORD_W +: COORD_W] <= COORD_W'(POS_DEFAULT + i*RESET_SPACING);
            end
            r_active   <= '0;
            r_sel_prev <= 1'b1;
            r_delta    <= COORD_W'(c_RST_DELTA);
        end else begin
            r_sel_prev <= w_lvl[2];
            if (w_inc_req || w_dec_req) begin
                r_pos[w_idx] <= COORD_W'(clamp_step(CALC_W'(r_pos[w_idx]),
                                                    w_inc_req ? DIR_INC : DIR_DEC,
                                                    CALC_W'(STEP),
                                                    CALC_W'(POS_MIN),
                                                    CALC_W'(POS_MAX)));
            end
            if (w_sel_edge) begin
                r_active <= (r_active == CURSOR_ID_W'(N_CURSORS - 1)) ? '0 : r_active + CURSOR_ID_W'(1);
            end
            for (int i = 0; i < N_CURSORS; i++) begin
                r_cursor_pos[i*COORD_W +: COORD_W] <= r_pos[i];
            end
            r_delta <= w_delta;
        end
    end

    if (N_CURSORS > 1) begin : g_delta
        assign w_delta = (r_pos[1] >= r_pos[0]) ? (r_pos[1] - r_pos[0]) : (r_pos[0] - r_pos[1]);
    end else begin : g_no_delta
        assign w_delta = '0;
    end

    logic [N_CURSORS-1:0]   w_hit;
    logic [CURSOR_ID_W-1:0] w_hit_id;

    for (genvar gh = 0; gh < N_CURSORS; gh++) begin : g_hit
        assign w_hit[gh] = ({1'b0, pix_coord} >= {1'b0, r_pos[gh]}) &&
                           ({1'b0, pix_coord} <= {1'b0, r_pos[gh]} + c_HIT_W'(LINE_W - 1));
    end

    always_comb begin
        w_hit_id = '0;
        for (int i = N_CURSORS - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_id = CURSOR_ID_W'(i);
            end
        end
    end

    assign in_cursor_line = |w_hit;
    assign cursor_hit_id  = w_hit_id;
    assign active_id      = r_active;
    assign cursor_pos     = r_cursor_pos;
    assign cursor_delta   = r_delta;

endmodule : cursor_bar_multi
`default_nettype wire

// File: tb/tb_cursor_bar_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_cursor_bar_multi
// Brief    : Directed scoreboard bench for cursor_bar_multi (N=2, LINE_W=3).
// Revision : 1.0
// ============================================================================
module tb_cursor_bar_multi;

    localparam int COORD_W = 11;
    localparam int N       = 2;

    logic                 clk_fpga = 1'b0;
    logic                 rst      = 1'b1;
    logic                 btn_dec  = 1'b0;
    logic                 btn_inc  = 1'b0;
    logic                 btn_sel  = 1'b0;
    logic [COORD_W-1:0]   pix_coord = '0;
    logic                 in_cursor_line;
    logic [2:0]           cursor_hit_id;
    logic [2:0]           active_id;
    logic [N*COORD_W-1:0] cursor_pos;
    logic [COORD_W-1:0]   cursor_delta;

    cursor_bar_multi #(
        .N_CURSORS       (N),
        .COORD_W         (COORD_W),
        .STEP            (16),
        .POS_MIN         (16),
        .POS_MAX         (1008),
        .POS_DEFAULT     (512),
        .RESET_SPACING   (64),
        .LINE_W          (3),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5),
        .DEBOUNCE_BYPASS (1'b1),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk_fpga       (clk_fpga),
        .rst            (rst),
        .btn_dec        (btn_dec),
        .btn_inc        (btn_inc),
        .btn_sel        (btn_sel),
        .pix_coord      (pix_coord),
        .in_cursor_line (in_cursor_line),
        .cursor_hit_id  (cursor_hit_id),
        .active_id      (active_id),
        .cursor_pos     (cursor_pos),
        .cursor_delta   (cursor_delta)
    );

    always #5 clk_fpga = ~clk_fpga;

    typedef enum int {F_POS0, F_POS1, F_ACTIVE, F_DELTA, F_LINE, F_HITID} field_e;
    typedef enum int {B_DEC, B_INC, B_SEL} btn_e;
    typedef struct {
        string  name;
        field_e f;
        int     exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [31:0] actual(field_e f);
        case (f)
            F_POS0:   return 32'(cursor_pos[0 +: COORD_W]);
            F_POS1:   return 32'(cursor_pos[COORD_W +: COORD_W]);
            F_ACTIVE: return 32'(active_id);
            F_DELTA:  return 32'(cursor_delta);
            F_LINE:   return 32'(in_cursor_line);
            F_HITID:  return 32'(cursor_hit_id);
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    always @(negedge clk_fpga) begin : mon
        exp_t e;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = actual(e.f);
            n_vec++;
            if (act !== 32'(e.exp)) begin
                n_miss++;
                $display("FAIL %s: got %0d, expected %0d", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_v(input string name, input field_e f, input int v);
        exp_t e;
        e.name = name;
        e.f    = f;
        e.exp  = v;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_fpga);
        #1;
    endtask

    task automatic set_btn(input btn_e b, input logic v);
        case (b)
            B_DEC:   btn_dec = v;
            B_INC:   btn_inc = v;
            default: btn_sel = v;
        endcase
    endtask

    task automatic tap(input btn_e b);
        set_btn(b, 1'b1);
        tick(3);
        set_btn(b, 1'b0);
        tick(4);
    endtask

    task automatic hold(input btn_e b, input int n);
        set_btn(b, 1'b1);
        tick(n);
        set_btn(b, 1'b0);
        tick(6);
    endtask

    task automatic pix_check(input int p, input int line, input int hid);
        pix_coord = COORD_W'(p);
        #1;
        expect_v($sformatf("line@%0d", p), F_LINE, line);
        if (line != 0) expect_v($sformatf("hitid@%0d", p), F_HITID, hid);
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb_q.size());
        $fatal(1);
    end

    initial begin : stim
        tick(3);
        rst = 1'b0;
        tick(2);

        if (cursor_pos[0 +: COORD_W] !== 11'd512) begin
            n_miss++;
            $display("FAIL direct_rst_pos0: got %0d, expected 512", cursor_pos[0 +: COORD_W]);
        end
        expect_v("rst_pos0", F_POS0, 512);
        expect_v("rst_pos1", F_POS1, 576);
        expect_v("rst_active", F_ACTIVE, 0);
        expect_v("rst_delta", F_DELTA, 64);
        expect_v("rst_line", F_LINE, 0);
        expect_v("rst_hitid", F_HITID, 0);
        tick(1);

        tap(B_INC);
        expect_v("tap_pos0", F_POS0, 528);
        expect_v("tap_pos1", F_POS1, 576);
        expect_v("tap_delta", F_DELTA, 48);
        tick(1);
        hold(B_INC, 40);
        expect_v("hold_pos0", F_POS0, 608);
        expect_v("hold_delta", F_DELTA, 32);
        tick(1);

        repeat (24) tap(B_INC);
        expect_v("to992", F_POS0, 992);
        tick(1);
        for (int k = 0; k < 3; k++) begin
            tap(B_INC);
            expect_v($sformatf("sat_hi%0d", k), F_POS0, 1008);
            tick(1);
        end

        repeat (61) tap(B_DEC);
        expect_v("to32", F_POS0, 32);
        tick(1);
        for (int k = 0; k < 3; k++) begin
            tap(B_DEC);
            expect_v($sformatf("sat_lo%0d", k), F_POS0, 16);
            tick(1);
        end

        tap(B_SEL);
        expect_v("sel_active1", F_ACTIVE, 1);
        tick(1);
        tap(B_DEC);
        expect_v("sel_pos1", F_POS1, 560);
        expect_v("sel_pos0", F_POS0, 16);
        expect_v("sel_delta", F_DELTA, 544);
        tick(1);
        tap(B_SEL);
        expect_v("sel_active0", F_ACTIVE, 0);
        tick(1);

        do_reset();
        pix_check(511, 0, 0);
        pix_check(512, 1, 0);
        pix_check(514, 1, 0);
        pix_check(515, 0, 0);
        pix_check(577, 1, 1);
        pix_check(578, 1, 1);
        pix_check(579, 0, 0);

        tap(B_SEL);
        repeat (4) tap(B_DEC);
        expect_v("ovl_pos1", F_POS1, 512);
        tick(1);
        pix_check(513, 1, 0);

        set_btn(B_INC, 1'b1);
        set_btn(B_DEC, 1'b1);
        tick(40);
        set_btn(B_INC, 1'b0);
        set_btn(B_DEC, 1'b0);
        tick(6);
        expect_v("both_pos1", F_POS1, 512);
        expect_v("both_pos0", F_POS0, 512);
        tick(1);

        tap(B_SEL);
        set_btn(B_INC, 1'b1);
        tick(10);
        expect_v("prehold_pos0", F_POS0, 528);
        tick(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(40);
        expect_v("rsthold_pos0", F_POS0, 512);
        expect_v("rsthold_pos1", F_POS1, 576);
        expect_v("rsthold_active", F_ACTIVE, 0);
        expect_v("rsthold_delta", F_DELTA, 64);
        tick(1);
        set_btn(B_INC, 1'b0);
        tick(6);
        expect_v("release_pos0", F_POS0, 512);
        tick(1);
        tap(B_INC);
        if (cursor_pos[0 +: COORD_W] !== 11'd528) begin
            n_miss++;
            $display("FAIL direct_repress_pos0: got %0d, expected 528", cursor_pos[0 +: COORD_W]);
        end
        expect_v("repress_pos0", F_POS0, 528);
        tick(2);

        if (n_vec < 12) begin
            n_miss++;
            $display("FAIL too few vectors applied: %0d", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        if (n_miss == 0) begin
            $display("PASS");
        end else begin
            $display("FAIL");
        end
        $finish;
    end

endmodule : tb_cursor_bar_multi
`default_nettype wire
